// File: rtl/apb_node_pkg.sv
// rtl/apb_node_pkg.sv - shared types and constants for the registered APB node
package apb_node_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_DECERR
    } apb_node_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADACCE5;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational priority window decoder, lowest port index wins
module apb_addr_decoder #(
    parameter int NB_MASTER      = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int IDX_W          = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1
) (
    input  logic [APB_ADDR_WIDTH-1:0]                addr,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr,
    output logic [NB_MASTER-1:0]                     sel_onehot,
    output logic [IDX_W-1:0]                         sel_idx,
    output logic                                     hit
);

    // Scan from the top so the lowest matching index is the last to write.
    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        hit        = 1'b0;
        for (int k = NB_MASTER - 1; k >= 0; k--) begin
            if ((addr >= start_addr[k]) && (addr <= end_addr[k])) begin
                sel_idx = IDX_W'(k);
                hit     = 1'b1;
            end
        end
        if (hit) begin
            sel_onehot[sel_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_node_reg.sv
// rtl/apb_node_reg.sv - registered APB node: one upstream slave, NB_MASTER downstream masters
module apb_node_reg
    import apb_node_pkg::*;
#(
    parameter int          NB_MASTER      = 4,
    parameter int          APB_ADDR_WIDTH = 32,
    parameter int          APB_DATA_WIDTH = 32,
    parameter int          TIMEOUT_CYCLES = 0,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                                     ACLK_i,
    input  logic                                     ARESETn_i,
    input  logic                                     PSEL_i,
    input  logic                                     PENABLE_i,
    input  logic                                     PWRITE_i,
    input  logic [APB_ADDR_WIDTH-1:0]                PADDR_i,
    input  logic [APB_DATA_WIDTH-1:0]                PWDATA_i,
    output logic [APB_DATA_WIDTH-1:0]                PRDATA_o,
    output logic                                     PREADY_o,
    output logic                                     PSLVERR_o,
    output logic [NB_MASTER-1:0]                     PSEL_o,
    output logic [NB_MASTER-1:0]                     PENABLE_o,
    output logic [NB_MASTER-1:0]                     PWRITE_o,
    output logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] PADDR_o,
    output logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] PWDATA_o,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] PRDATA_i,
    input  logic [NB_MASTER-1:0]                     PREADY_i,
    input  logic [NB_MASTER-1:0]                     PSLVERR_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] START_ADDR_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] END_ADDR_i,
    output logic                                     TIMEOUT_o
);

    localparam int IDX_W    = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic [APB_DATA_WIDTH-1:0] ERR_D    = APB_DATA_WIDTH'(ERR_DATA);

    apb_node_state_e state_q, state_d;

    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic                      write_q;
    logic [NB_MASTER-1:0]      sel_q;
    logic [IDX_W-1:0]          idx_q;
    logic [CNT_W-1:0]          cnt_q;

    logic [NB_MASTER-1:0] dec_sel;
    logic [IDX_W-1:0]     dec_idx;
    logic                 dec_hit;

    logic accept, slv_ready, wd_expire;

    logic [APB_ADDR_WIDTH-1:0] addr_eff;
    logic [APB_DATA_WIDTH-1:0] wdata_eff;
    logic                      write_eff;
    logic [NB_MASTER-1:0]      sel_eff;

    logic [NB_MASTER-1:0]                     psel_d, pen_d, pwrite_d;
    logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] paddr_d;
    logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] pwdata_d;
    logic [APB_DATA_WIDTH-1:0]                prdata_d;
    logic                                     pready_d, pslverr_d, timeout_d;

    apb_addr_decoder #(
        .NB_MASTER      (NB_MASTER),
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .IDX_W          (IDX_W)
    ) u_decoder (
        .addr       (PADDR_i),
        .start_addr (START_ADDR_i),
        .end_addr   (END_ADDR_i),
        .sel_onehot (dec_sel),
        .sel_idx    (dec_idx),
        .hit        (dec_hit)
    );

    assign accept    = (state_q == ST_IDLE) && PSEL_i && !PENABLE_i;
    assign slv_ready = PREADY_i[idx_q];
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = dec_hit ? ST_SETUP : ST_DECERR;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (slv_ready || wd_expire) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            ST_DECERR: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            addr_q  <= PADDR_i;
            wdata_q <= PWRITE_i ? PWDATA_i : '0;
            write_q <= PWRITE_i;
            sel_q   <= dec_sel;
            idx_q   <= dec_idx;
        end
    end

    // Counts completed ACCESS cycles; the abort fires while the last allowed one is in progress.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            cnt_q <= '0;
        end else if (state_d == ST_SETUP) begin
            cnt_q <= '0;
        end else if ((state_q == ST_ACCESS) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The downstream bus is driven from the value being registered this edge.
    assign addr_eff  = accept ? PADDR_i : addr_q;
    assign wdata_eff = accept ? (PWRITE_i ? PWDATA_i : '0) : wdata_q;
    assign write_eff = accept ? PWRITE_i : write_q;
    assign sel_eff   = accept ? dec_sel : sel_q;

    always_comb begin
        psel_d    = '0;
        pen_d     = '0;
        pwrite_d  = '0;
        paddr_d   = '0;
        pwdata_d  = '0;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        timeout_d = 1'b0;
        if ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) begin
            for (int k = 0; k < NB_MASTER; k++) begin
                if (sel_eff[k]) begin
                    psel_d[k]   = 1'b1;
                    pen_d[k]    = (state_d == ST_ACCESS);
                    pwrite_d[k] = write_eff;
                    paddr_d[k]  = addr_eff;
                    pwdata_d[k] = wdata_eff;
                end
            end
        end
        case (state_d)
            ST_RESP: begin
                pready_d = 1'b1;
                if (slv_ready) begin
                    prdata_d  = PRDATA_i[idx_q];
                    pslverr_d = PSLVERR_i[idx_q];
                end else begin
                    pslverr_d = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_DECERR: begin
                pready_d  = 1'b1;
                pslverr_d = 1'b1;
                prdata_d  = ERR_D;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            PSEL_o    <= '0;
            PENABLE_o <= '0;
            PWRITE_o  <= '0;
            PADDR_o   <= '0;
            PWDATA_o  <= '0;
            PRDATA_o  <= '0;
            PREADY_o  <= 1'b0;
            PSLVERR_o <= 1'b0;
            TIMEOUT_o <= 1'b0;
        end else begin
            PSEL_o    <= psel_d;
            PENABLE_o <= pen_d;
            PWRITE_o  <= pwrite_d;
            PADDR_o   <= paddr_d;
            PWDATA_o  <= pwdata_d;
            PRDATA_o  <= prdata_d;
            PREADY_o  <= pready_d;
            PSLVERR_o <= pslverr_d;
            TIMEOUT_o <= timeout_d;
        end
    end

endmodule

// File: tb/tb_apb_node_reg.sv
// tb/tb_apb_node_reg.sv - self-checking bench for apb_node_reg against a transaction timeline model
module tb_apb_node_reg;

    localparam int NB    = 4;
    localparam int TO    = 8;
    localparam int EXP_N = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             psel_i, penable_i, pwrite_i;
    logic [31:0]      paddr_i, pwdata_i;
    logic [31:0]      PRDATA_o;
    logic             PREADY_o, PSLVERR_o, TIMEOUT_o;
    logic [NB-1:0]    PSEL_o, PENABLE_o, PWRITE_o;
    logic [NB-1:0][31:0] PADDR_o, PWDATA_o, PRDATA_i, START_ADDR, END_ADDR;
    logic [NB-1:0]    PREADY_i, PSLVERR_i;

    logic [31:0] win_lo [NB] = '{32'h1000, 32'h2000, 32'h3000, 32'h1800};
    logic [31:0] win_hi [NB] = '{32'h1FFF, 32'h2FFF, 32'h3FFF, 32'h18FF};

    apb_node_reg #(
        .NB_MASTER      (NB),
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (32'hBADACCE5)
    ) dut (
        .ACLK_i       (clk),
        .ARESETn_i    (rst_n),
        .PSEL_i       (psel_i),
        .PENABLE_i    (penable_i),
        .PWRITE_i     (pwrite_i),
        .PADDR_i      (paddr_i),
        .PWDATA_i     (pwdata_i),
        .PRDATA_o     (PRDATA_o),
        .PREADY_o     (PREADY_o),
        .PSLVERR_o    (PSLVERR_o),
        .PSEL_o       (PSEL_o),
        .PENABLE_o    (PENABLE_o),
        .PWRITE_o     (PWRITE_o),
        .PADDR_o      (PADDR_o),
        .PWDATA_o     (PWDATA_o),
        .PRDATA_i     (PRDATA_i),
        .PREADY_i     (PREADY_i),
        .PSLVERR_i    (PSLVERR_i),
        .START_ADDR_i (START_ADDR),
        .END_ADDR_i   (END_ADDR),
        .TIMEOUT_o    (TIMEOUT_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // Expected outputs per cycle number; zero everywhere no transfer claims.
    logic [3:0]  e_psel [EXP_N];
    logic [3:0]  e_pen  [EXP_N];
    logic        e_wr   [EXP_N];
    logic [31:0] e_addr [EXP_N];
    logic [31:0] e_wdata[EXP_N];
    logic [31:0] e_prdata[EXP_N];
    logic        e_pready[EXP_N];
    logic        e_err  [EXP_N];
    logic        e_to   [EXP_N];

    int          cur_w  = 0;
    logic [31:0] cur_rd = '0;
    logic        cur_er = 1'b0;
    int          acc    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    endtask

    task automatic clear_exp(input int lo, input int hi);
        for (int i = lo; i <= hi && i < EXP_N; i++) begin
            e_psel[i] = '0; e_pen[i] = '0; e_wr[i] = 1'b0; e_addr[i] = '0; e_wdata[i] = '0;
            e_prdata[i] = '0; e_pready[i] = 1'b0; e_err[i] = 1'b0; e_to[i] = 1'b0;
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < NB; k++)
            if (a >= win_lo[k] && a <= win_hi[k]) return k;
        return -1;
    endfunction

    // Per-cycle compare against the timeline, then the downstream slave model.
    always @(negedge clk) begin
        logic [127:0] xa, xw;
        logic [3:0]   xwr;
        logic         rdy;
        int           c;
        c = cyc;
        if (c < EXP_N) begin
            xa = '0; xw = '0; xwr = '0;
            for (int j = 0; j < NB; j++) begin
                if (e_psel[c][j]) begin
                    xa[j*32 +: 32] = e_addr[c];
                    xw[j*32 +: 32] = e_wdata[c];
                    xwr[j]         = e_wr[c];
                end
            end
            chk("psel", PSEL_o, e_psel[c]);
            chk("penable", PENABLE_o, e_pen[c]);
            chk("pwrite", PWRITE_o, xwr);
            chk("paddr", PADDR_o, xa);
            chk("pwdata", PWDATA_o, xw);
            chk("pready", PREADY_o, e_pready[c]);
            chk("pslverr", PSLVERR_o, e_err[c]);
            chk("prdata", PRDATA_o, e_prdata[c]);
            chk("timeout", TIMEOUT_o, e_to[c]);
        end
        if (|(PSEL_o & PENABLE_o)) begin
            rdy = (acc == cur_w);
            acc++;
        end else begin
            rdy = 1'b0;
            acc = 0;
        end
        for (int k = 0; k < NB; k++) begin
            PREADY_i[k]  = rdy && PSEL_o[k] && PENABLE_o[k];
            PRDATA_i[k]  = rdy ? cur_rd : ~cur_rd;
            PSLVERR_i[k] = rdy ? cur_er : ~cur_er;
        end
    end

    // Called just after a rising edge; returns one cycle after the response cycle.
    task automatic do_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                           input int w, input logic [31:0] rd, input logic er,
                           output int lat, output logic [31:0] prd, output logic perr,
                           output logic pto, output logic [3:0] s_psel, output logic [127:0] s_paddr,
                           output logic [127:0] s_pwdata);
        int c0, k, n;
        logic to;
        c0 = cyc;
        cur_w = w; cur_rd = rd; cur_er = er;
        k = decode(a);
        if (k < 0) begin
            e_pready[c0+1] = 1'b1; e_err[c0+1] = 1'b1; e_prdata[c0+1] = 32'hBADACCE5;
        end else begin
            to = (w + 1 > TO);
            n  = to ? TO : w + 1;
            for (int i = 1; i <= n + 1; i++) begin
                e_psel[c0+i]  = 4'(1 << k);
                e_pen[c0+i]   = (i >= 2) ? 4'(1 << k) : 4'b0;
                e_addr[c0+i]  = a;
                e_wr[c0+i]    = wr;
                e_wdata[c0+i] = wr ? wd : 32'h0;
            end
            e_pready[c0+n+2] = 1'b1;
            e_prdata[c0+n+2] = to ? 32'h0 : rd;
            e_err[c0+n+2]    = to ? 1'b1 : er;
            e_to[c0+n+2]     = to;
        end
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = a; pwrite_i = wr; pwdata_i = wd;
        lat = -1; prd = '0; perr = 1'b0; pto = 1'b0; s_psel = '0; s_paddr = '0; s_pwdata = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            penable_i = 1'b1;
            @(negedge clk);
            if (i == 1) begin
                s_psel = PSEL_o; s_paddr = PADDR_o; s_pwdata = PWDATA_o;
            end
            if (PREADY_o) begin
                lat = i; prd = PRDATA_o; perr = PSLVERR_o; pto = TIMEOUT_o;
                break;
            end
        end
        if (lat < 0) chk("xfer_bound", 0, 1);
        @(posedge clk); #1;
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time bound expired");
    end

    initial begin
        int          lat, k, n, w, gap;
        logic [31:0] prd, a, wd, rd;
        logic        perr, pto, wr, er;
        logic [3:0]  s_psel;
        logic [127:0] s_paddr, s_pwdata;

        clear_exp(0, EXP_N - 1);
        for (int i = 0; i < NB; i++) begin
            START_ADDR[i] = win_lo[i];
            END_ADDR[i]   = win_hi[i];
        end
        psel_i = 0; penable_i = 0; pwrite_i = 0; paddr_i = '0; pwdata_i = '0;
        PREADY_i = '0; PSLVERR_i = '0; PRDATA_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_pready", PREADY_o, 0);
        chk("reset_psel", PSEL_o, 0);

        do_xfer(32'h2004, 1'b1, 32'hCAFEF00D, 0, 32'h0, 1'b0, lat, prd, perr, pto, s_psel, s_paddr, s_pwdata);
        chk("wr_lat", lat, 3);
        chk("wr_psel", s_psel, 4'b0010);
        chk("wr_paddr1", s_paddr[63:32], 32'h2004);
        chk("wr_pwdata1", s_pwdata[63:32], 32'hCAFEF00D);
        chk("wr_err", perr, 0);

        do_xfer(32'h1810, 1'b0, 32'h0, 2, 32'h12345678, 1'b0, lat, prd, perr, pto, s_psel, s_paddr, s_pwdata);
        chk("ovl_lat", lat, 5);
        chk("ovl_psel", s_psel, 4'b0001);
        chk("ovl_prdata", prd, 32'h12345678);

        do_xfer(32'h8000, 1'b0, 32'h0, 0, 32'h0, 1'b0, lat, prd, perr, pto, s_psel, s_paddr, s_pwdata);
        chk("dec_lat", lat, 1);
        chk("dec_psel", s_psel, 4'b0000);
        chk("dec_err", perr, 1);
        chk("dec_prdata", prd, 32'hBADACCE5);

        do_xfer(32'h3100, 1'b0, 32'h0, 1000, 32'h77777777, 1'b0, lat, prd, perr, pto, s_psel, s_paddr, s_pwdata);
        chk("to_lat", lat, 10);
        chk("to_pulse", pto, 1);
        chk("to_err", perr, 1);
        chk("to_prdata", prd, 32'h0);

        do_xfer(32'h3200, 1'b0, 32'h0, 7, 32'hA5A5F00F, 1'b0, lat, prd, perr, pto, s_psel, s_paddr, s_pwdata);
        chk("last_lat", lat, 10);
        chk("last_pulse", pto, 0);
        chk("last_err", perr, 0);
        chk("last_prdata", prd, 32'hA5A5F00F);

        // Reset lands in the middle of ACCESS on port 2.
        begin
            int c0;
            c0 = cyc;
            cur_w = 1000;
            psel_i = 1; penable_i = 0; paddr_i = 32'h3010; pwrite_i = 1; pwdata_i = 32'h55AA55AA;
            for (int i = 1; i <= 2; i++) begin
                e_psel[c0+i] = 4'b0100; e_pen[c0+i] = (i == 2) ? 4'b0100 : 4'b0;
                e_addr[c0+i] = 32'h3010; e_wr[c0+i] = 1'b1; e_wdata[c0+i] = 32'h55AA55AA;
            end
            @(posedge clk); #1 penable_i = 1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("pre_rst_psel", PSEL_o, 4'b0100);
            chk("pre_rst_pen", PENABLE_o, 4'b0100);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_psel", PSEL_o, 0);
            chk("rst_pen", PENABLE_o, 0);
            chk("rst_paddr", PADDR_o, 0);
            chk("rst_pwdata", PWDATA_o, 0);
            @(posedge clk);
            @(posedge clk); #1;
            rst_n = 1'b1; psel_i = 0; penable_i = 0;
            repeat (2) begin @(posedge clk); #1; end
        end
        do_xfer(32'h3020, 1'b0, 32'h0, 0, 32'h0BADF00D, 1'b1, lat, prd, perr, pto, s_psel, s_paddr, s_pwdata);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_err", perr, 1);

        for (int t = 0; t < 60; t++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                psel_i = 1'($urandom); penable_i = 1'b1; paddr_i = $urandom; pwrite_i = 1'($urandom);
                @(posedge clk); #1;
            end
            case ($urandom_range(0, 4))
                0: a = 32'h1000 + ($urandom % 32'h1000);
                1: a = 32'h2000 + ($urandom % 32'h1000);
                2: a = 32'h3000 + ($urandom % 32'h1000);
                3: a = 32'h1800 + ($urandom % 32'h100);
                default: a = ($urandom % 2) ? ($urandom % 32'h1000) : ($urandom | 32'h0001_0000);
            endcase
            wr = 1'($urandom); wd = $urandom; rd = $urandom; er = 1'($urandom);
            w  = $urandom_range(0, 10);
            do_xfer(a, wr, wd, w, rd, er, lat, prd, perr, pto, s_psel, s_paddr, s_pwdata);
            k = decode(a);
            n = (w + 1 > TO) ? TO : w + 1;
            chk("rand_lat", lat, (k < 0) ? 1 : n + 2);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
